// File: rtl/nand_cpu_pkg.sv
// Shared types and constants for the nand_cpu decode path.
//
// Contents:
//   PKT_ADDR_W   - register address width carried in decode packets (wide
//                  enough for the largest register file, 256 entries)
//   ALU_OP       - ALU operation selector, ALU_NOP when the ALU is unused
//   MEM_OP       - memory direction, meaningful only with mem_access
//   dec_state_t  - decode stage control states
//   decode_pkt_t - fully decoded instruction
//   OPC_*        - 4-bit major opcodes (instr[7:4]); LI uses a 2-bit prefix
package nand_cpu_pkg;

    localparam int PKT_ADDR_W = 8;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_CL  = 4'd1,
        ALU_CP  = 4'd2,
        ALU_NND = 4'd3,
        ALU_LS  = 4'd4,
        ALU_RS  = 4'd5,
        ALU_EQ  = 4'd6,
        ALU_NE  = 4'd7,
        ALU_LI  = 4'd8
    } ALU_OP;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } MEM_OP;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic                  use_ra;
        logic                  use_rt;
        logic [PKT_ADDR_W-1:0] rt_addr;
        logic                  use_rw;
        logic [PKT_ADDR_W-1:0] rw_addr;
        logic                  read_ps;
        logic                  write_ps;
        logic                  use_immdt;
        logic [3:0]            immdt;
        logic [1:0]            shift;
        logic                  mem_access;
        MEM_OP                 mem_op;
        logic                  jump;
        logic                  branch;
        logic                  interrupt;
        logic                  halt;
        ALU_OP                 alu_op;
    } decode_pkt_t;

    localparam logic [3:0] OPC_CLCP = 4'b0000;
    localparam logic [3:0] OPC_NND  = 4'b0001;
    localparam logic [3:0] OPC_LS   = 4'b0010;
    localparam logic [3:0] OPC_RS   = 4'b0011;
    localparam logic [3:0] OPC_EQ   = 4'b0100;
    localparam logic [3:0] OPC_NE   = 4'b0101;
    localparam logic [3:0] OPC_BR   = 4'b0110;
    localparam logic [3:0] OPC_JRL  = 4'b0111;
    localparam logic [3:0] OPC_LD   = 4'b1100;
    localparam logic [3:0] OPC_ST   = 4'b1101;
    localparam logic [3:0] OPC_INT  = 4'b1110;
    localparam logic [3:0] OPC_HLT  = 4'b1111;
    localparam logic [1:0] OPC_LI   = 2'b10;

endpackage

// File: rtl/nand_decode_logic.sv
// Pure combinational instruction decoder: 8-bit instruction to decode_pkt_t.
//
// Ports:
//   instr_i  in   8                    instruction byte
//   pkt_o    out  $bits(decode_pkt_t)  decoded packet
//
// The raw rt/immdt/shift fields are always filled in; the use_* flags say
// which of them matter. r0 is the implicit ra and the default rw.
module nand_decode_logic
    import nand_cpu_pkg::*;
(
    input  logic [7:0]  instr_i,
    output decode_pkt_t pkt_o
);

    always_comb begin
        pkt_o         = '0;
        pkt_o.rt_addr = PKT_ADDR_W'(instr_i[3:0]);
        pkt_o.immdt   = instr_i[3:0];
        pkt_o.shift   = instr_i[5:4];

        if (instr_i[7:6] == OPC_LI) begin
            pkt_o.use_ra    = 1'b1;
            pkt_o.use_rw    = 1'b1;
            pkt_o.use_immdt = 1'b1;
            pkt_o.alu_op    = ALU_LI;
        end else begin
            case (instr_i[7:4])
                OPC_CLCP: begin
                    // 0x00 is CL; any other 0000xxxx copies r0 into rw.
                    pkt_o.use_rw = 1'b1;
                    if (instr_i[3:0] == 4'd0) begin
                        pkt_o.alu_op = ALU_CL;
                    end else begin
                        pkt_o.use_ra  = 1'b1;
                        pkt_o.rw_addr = PKT_ADDR_W'(instr_i[3:0]);
                        pkt_o.alu_op  = ALU_CP;
                    end
                end
                OPC_NND, OPC_LS, OPC_RS: begin
                    pkt_o.use_ra = 1'b1;
                    pkt_o.use_rt = 1'b1;
                    pkt_o.use_rw = 1'b1;
                    pkt_o.alu_op = (instr_i[7:4] == OPC_NND) ? ALU_NND :
                                   (instr_i[7:4] == OPC_LS)  ? ALU_LS  : ALU_RS;
                end
                OPC_EQ, OPC_NE: begin
                    pkt_o.use_ra   = 1'b1;
                    pkt_o.use_rt   = 1'b1;
                    pkt_o.write_ps = 1'b1;
                    pkt_o.alu_op   = (instr_i[7:4] == OPC_EQ) ? ALU_EQ : ALU_NE;
                end
                OPC_BR: begin
                    pkt_o.use_rt  = 1'b1;
                    pkt_o.read_ps = 1'b1;
                    pkt_o.branch  = 1'b1;
                end
                OPC_JRL: begin
                    pkt_o.use_rt  = 1'b1;
                    pkt_o.use_rw  = 1'b1;
                    pkt_o.rw_addr = PKT_ADDR_W'(instr_i[3:0]);
                    pkt_o.jump    = 1'b1;
                end
                OPC_LD: begin
                    pkt_o.use_rt     = 1'b1;
                    pkt_o.use_rw     = 1'b1;
                    pkt_o.mem_access = 1'b1;
                    pkt_o.mem_op     = MEM_READ;
                end
                OPC_ST: begin
                    pkt_o.use_ra     = 1'b1;
                    pkt_o.use_rt     = 1'b1;
                    pkt_o.mem_access = 1'b1;
                    pkt_o.mem_op     = MEM_WRITE;
                end
                OPC_INT: pkt_o.interrupt = 1'b1;
                OPC_HLT: pkt_o.halt      = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nand_decode_stage.sv
// Registered, flow-controlled decode stage between fetch and register-read.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        fetch handshake, in_instr is the instruction byte
//   out_valid/out_ready      downstream handshake, out_pkt is the decoded packet
//   wb_valid, wb_addr        register writeback retiring a pending write
//   ps_wb_valid              predicate writeback retiring the pending PS write
//   flush                    squash in-flight packet and scoreboard
//   halted                   HLT has been accepted (sticky until rst)
//   sb_empty                 no register or PS write outstanding
//
// A per-register pending bit plus a PS pending bit stall RAW/WAW hazards.
// INT waits in DRAIN until every outstanding write has retired.
module nand_decode_stage
    import nand_cpu_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int REG_ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output decode_pkt_t           out_pkt,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic                  ps_wb_valid,
    input  logic                  flush,
    output logic                  halted,
    output logic                  sb_empty
);

    dec_state_t          state_q, state_d;
    decode_pkt_t         dec_pkt, pkt_q, pkt_d;
    logic                pkt_vld_q, pkt_vld_d;
    logic [NUM_REGS-1:0] pend_q, pend_d, pend_eff, wb_clr, rw_set;
    logic                ps_pend_q, ps_pend_d, ps_pend_eff;
    logic                hazard, in_fire, out_fire;
    logic [REG_ADDR_W-1:0] rt_idx, rw_idx;

    nand_decode_logic u_dec (
        .instr_i (in_instr),
        .pkt_o   (dec_pkt)
    );

    // Packet addresses are zero-extended ISA fields; trim to the file size.
    assign rt_idx = REG_ADDR_W'(dec_pkt.rt_addr);
    assign rw_idx = REG_ADDR_W'(dec_pkt.rw_addr);

    // Same-cycle writeback bypass: a retiring entry no longer blocks issue.
    assign wb_clr      = wb_valid ? (NUM_REGS'(1) << wb_addr) : '0;
    assign pend_eff    = pend_q & ~wb_clr;
    assign ps_pend_eff = ps_pend_q & ~ps_wb_valid;

    assign hazard = (dec_pkt.use_ra && pend_eff[0])
                 || (dec_pkt.use_rt && pend_eff[rt_idx])
                 || (dec_pkt.use_rw && pend_eff[rw_idx])
                 || ((dec_pkt.read_ps || dec_pkt.write_ps) && ps_pend_eff);

    assign sb_empty  = ~|pend_q && !ps_pend_q;
    assign halted    = (state_q == HALTED);
    assign out_pkt   = pkt_q;
    // An INT packet sits hidden in DRAIN until the scoreboard empties.
    assign out_valid = pkt_vld_q && !((state_q == DRAIN) && !sb_empty);
    assign in_ready  = !rst && (state_q == RUN) && (!pkt_vld_q || out_ready)
                    && !hazard && !flush;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign rw_set   = (in_fire && dec_pkt.use_rw) ? (NUM_REGS'(1) << rw_idx) : '0;

    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        pkt_vld_d = pkt_vld_q;
        // Set is applied after clear so a same-cycle set wins.
        pend_d    = (pend_q & ~wb_clr) | rw_set;
        ps_pend_d = (ps_pend_q & ~ps_wb_valid) | (in_fire && dec_pkt.write_ps);

        if (in_fire) begin
            pkt_d     = dec_pkt;
            pkt_vld_d = 1'b1;
        end else if (out_fire) begin
            pkt_vld_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (in_fire && dec_pkt.interrupt) begin
                    state_d = DRAIN;
                end else if (in_fire && dec_pkt.halt) begin
                    state_d = HALTED;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    state_d = RUN;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase

        // Flush overrides everything except the sticky halt.
        if (flush) begin
            pkt_vld_d = 1'b0;
            pend_d    = '0;
            ps_pend_d = 1'b0;
            if (state_q == DRAIN) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pkt_q     <= '0;
            pkt_vld_q <= 1'b0;
            pend_q    <= '0;
            ps_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            pkt_vld_q <= pkt_vld_d;
            pend_q    <= pend_d;
            ps_pend_q <= ps_pend_d;
        end
    end

endmodule
